// File: rtl/race_stopwatch.sv
// rtl/race_stopwatch.sv - MM:SS.cc race stopwatch with BCD digits, binary total and saturation
module race_stopwatch #(
    parameter int MAX_MIN = 59
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    output logic        running,
    output logic        saturated,
    output logic [3:0]  cs_ones,
    output logic [3:0]  cs_tens,
    output logic [3:0]  sec_ones,
    output logic [3:0]  sec_tens,
    output logic [3:0]  min_ones,
    output logic [3:0]  min_tens,
    output logic [18:0] elapsed_cs
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_SAT   = 2'd3;

    // Largest representable count, MAX_MIN:59.99, expressed in centiseconds
    localparam logic [18:0] MAX_CS = 19'(MAX_MIN * 6000 + 5999);

    logic [1:0] state;
    logic [1:0] state_next;
    logic       do_inc;
    logic       do_zero;
    logic       hits_max;

    // The next increment lands exactly on the maximum time
    assign hits_max = (elapsed_cs == (MAX_CS - 19'd1));

    // Next-state and count-control decode; clear beats stop beats start
    always_comb begin
        state_next = state;
        do_inc     = 1'b0;
        do_zero    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_RUN;
            end
            S_RUN: begin
                if (clear) begin
                    state_next = S_IDLE;
                    do_zero    = 1'b1;
                end else begin
                    if (stop) state_next = S_PAUSE;
                    if (tick) begin
                        do_inc = 1'b1;
                        if (hits_max) state_next = S_SAT;
                    end
                end
            end
            S_PAUSE: begin
                if (clear) begin
                    state_next = S_IDLE;
                    do_zero    = 1'b1;
                end else if (start) begin
                    state_next = S_RUN;
                end
            end
            default: begin
                if (clear) begin
                    state_next = S_IDLE;
                    do_zero    = 1'b1;
                end
            end
        endcase
    end

    // State, status flags and the BCD/binary counters advance together
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            running    <= 1'b0;
            saturated  <= 1'b0;
            cs_ones    <= 4'd0;
            cs_tens    <= 4'd0;
            sec_ones   <= 4'd0;
            sec_tens   <= 4'd0;
            min_ones   <= 4'd0;
            min_tens   <= 4'd0;
            elapsed_cs <= 19'd0;
        end else begin
            state     <= state_next;
            running   <= (state_next == S_RUN);
            saturated <= (state_next == S_SAT);
            if (do_zero) begin
                cs_ones    <= 4'd0;
                cs_tens    <= 4'd0;
                sec_ones   <= 4'd0;
                sec_tens   <= 4'd0;
                min_ones   <= 4'd0;
                min_tens   <= 4'd0;
                elapsed_cs <= 19'd0;
            end else if (do_inc) begin
                elapsed_cs <= elapsed_cs + 19'd1;
                if (cs_ones == 4'd9) begin
                    cs_ones <= 4'd0;
                    if (cs_tens == 4'd9) begin
                        cs_tens <= 4'd0;
                        if (sec_ones == 4'd9) begin
                            sec_ones <= 4'd0;
                            if (sec_tens == 4'd5) begin
                                sec_tens <= 4'd0;
                                if (min_ones == 4'd9) begin
                                    min_ones <= 4'd0;
                                    min_tens <= min_tens + 4'd1;
                                end else begin
                                    min_ones <= min_ones + 4'd1;
                                end
                            end else begin
                                sec_tens <= sec_tens + 4'd1;
                            end
                        end else begin
                            sec_ones <= sec_ones + 4'd1;
                        end
                    end else begin
                        cs_tens <= cs_tens + 4'd1;
                    end
                end else begin
                    cs_ones <= cs_ones + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_race_stopwatch.sv
// tb/tb_race_stopwatch.sv - directed and randomized bench for race_stopwatch against a count model
module tb_race_stopwatch;

    logic clk = 1'b0;
    logic rst, tick, start, stop, clear;

    logic        run_a, sat_a, run_b, sat_b;
    logic [3:0]  co_a, ct_a, so_a, st_a, mo_a, mt_a;
    logic [3:0]  co_b, ct_b, so_b, st_b, mo_b, mt_b;
    logic [18:0] el_a, el_b;

    int checks = 0;
    int errors = 0;

    // Model: 0 idle, 1 run, 2 pause, 3 saturated; count in centiseconds
    int m_st[2];
    int m_cnt[2];
    int m_max[2];

    always #5 clk = ~clk;

    race_stopwatch #(.MAX_MIN(59)) dut_a (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .clear(clear),
        .running(run_a), .saturated(sat_a),
        .cs_ones(co_a), .cs_tens(ct_a), .sec_ones(so_a), .sec_tens(st_a),
        .min_ones(mo_a), .min_tens(mt_a), .elapsed_cs(el_a)
    );

    race_stopwatch #(.MAX_MIN(0)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .clear(clear),
        .running(run_b), .saturated(sat_b),
        .cs_ones(co_b), .cs_tens(ct_b), .sec_ones(so_b), .sec_tens(st_b),
        .min_ones(mo_b), .min_tens(mt_b), .elapsed_cs(el_b)
    );

    function automatic logic [44:0] mk(input logic run, input logic sat, input int m, input int s, input int c);
        return {run, sat, 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
                4'(c / 10), 4'(c % 10), 19'(m * 6000 + s * 100 + c)};
    endfunction

    function automatic logic [44:0] model_exp(input int i);
        return mk(m_st[i] == 1, m_st[i] == 3, m_cnt[i] / 6000, (m_cnt[i] / 100) % 60, m_cnt[i] % 100);
    endfunction

    function automatic logic [44:0] obs(input int i);
        if (i == 0) return {run_a, sat_a, mt_a, mo_a, st_a, so_a, ct_a, co_a, el_a};
        return {run_b, sat_b, mt_b, mo_b, st_b, so_b, ct_b, co_b, el_b};
    endfunction

    task automatic chk(input string tag, input logic [44:0] o, input logic [44:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic model_step(input int i);
        if (rst) begin
            m_st[i] = 0;
            m_cnt[i] = 0;
        end else begin
            case (m_st[i])
                0: if (start) m_st[i] = 1;
                1: begin
                    if (clear) begin
                        m_st[i] = 0;
                        m_cnt[i] = 0;
                    end else begin
                        if (stop) m_st[i] = 2;
                        if (tick) m_cnt[i]++;
                        if (m_cnt[i] == m_max[i]) m_st[i] = 3;
                    end
                end
                2: begin
                    if (clear) begin
                        m_st[i] = 0;
                        m_cnt[i] = 0;
                    end else if (start) begin
                        m_st[i] = 1;
                    end
                end
                default: begin
                    if (clear) begin
                        m_st[i] = 0;
                        m_cnt[i] = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic cyc(input logic s, input logic p, input logic c, input logic t, input logic r);
        start = s; stop = p; clear = c; tick = t; rst = r;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        chk("model_max59", obs(0), model_exp(0));
        chk("model_max0", obs(1), model_exp(1));
        start = 0; stop = 0; clear = 0; tick = 0; rst = 0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            cyc(0, 0, 0, 1, 0);
            cyc(0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        m_max[0] = 59 * 6000 + 5999;
        m_max[1] = 5999;
        m_st = '{0, 0};
        m_cnt = '{0, 0};
        rst = 1; tick = 0; start = 0; stop = 0; clear = 0;

        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("reset_a", obs(0), mk(0, 0, 0, 0, 0));
        chk("reset_b", obs(1), mk(0, 0, 0, 0, 0));

        // 100 ticks make one second
        cyc(1, 0, 0, 0, 0);
        ticks(100);
        chk("one_second", obs(0), mk(1, 0, 0, 1, 0));

        // 6000 ticks from zero make one minute; the MAX_MIN=0 copy pins at 00:59.99
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        ticks(6000);
        chk("one_minute", obs(0), mk(1, 0, 1, 0, 0));
        chk("sat_during_minute", obs(1), mk(0, 1, 0, 59, 99));

        // Reset mid-run at 01:00.00
        cyc(0, 0, 0, 0, 1);
        chk("reset_midrun", obs(0), mk(0, 0, 0, 0, 0));

        // Stop coincident with a tick counts the tick; paused ticks are ignored
        cyc(1, 0, 0, 0, 0);
        ticks(41);
        cyc(0, 1, 0, 1, 0);
        chk("stop_with_tick", obs(0), mk(0, 0, 0, 0, 42));
        ticks(50);
        chk("paused_ticks", obs(0), mk(0, 0, 0, 0, 42));
        cyc(1, 0, 0, 0, 0);
        ticks(3);
        chk("resume", obs(0), mk(1, 0, 0, 0, 45));

        // Clear coincident with a tick drops the tick
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        ticks(1234);
        chk("at_12_34", obs(0), mk(1, 0, 0, 12, 34));
        cyc(0, 0, 1, 1, 0);
        chk("clear_with_tick", obs(0), mk(0, 0, 0, 0, 0));

        // Saturation at 00:59.99 when MAX_MIN=0, then hold, then clear
        cyc(1, 0, 0, 0, 0);
        ticks(5999);
        chk("saturate", obs(1), mk(0, 1, 0, 59, 99));
        chk("no_sat_59", obs(0), mk(1, 0, 0, 59, 99));
        ticks(5);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0);
        chk("sat_hold", obs(1), mk(0, 1, 0, 59, 99));
        cyc(0, 0, 1, 0, 0);
        chk("sat_clear", obs(1), mk(0, 0, 0, 0, 0));

        // Start coincident with a tick does not count it
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 1, 0);
        chk("start_with_tick", obs(0), mk(1, 0, 0, 0, 0));
        ticks(1);
        chk("first_tick", obs(0), mk(1, 0, 0, 0, 1));

        // Randomized control mix checked each cycle against the model
        for (int k = 0; k < 4000; k++) begin
            cyc($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 4, $urandom_range(0, 199) < 2,
                $urandom_range(0, 99) < 35, $urandom_range(0, 999) < 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
